// File: rtl/tcdm_arb_pkg.sv
// Shared types and the round-robin search used by the TCDM bank arbiters.
// Indices are carried at a fixed maximum width so one function serves every arbiter size.
package tcdm_arb_pkg;

  localparam int unsigned MaxInit = 32;
  localparam int unsigned IdxW    = $clog2(MaxInit);

  typedef logic [IdxW-1:0] init_idx_t;

  // Architectural state of one bank arbiter, kept together so it can be probed as a unit.
  typedef struct packed {
    logic      lock;
    init_idx_t locked_idx;
    init_idx_t rr_ptr;
    logic      rvld;
    init_idx_t ridx;
  } arb_state_t;

  // First requesting index at or after ptr among the lowest n lanes, wrapping at n.
  function automatic init_idx_t rr_pick(input logic [MaxInit-1:0] req,
                                        input init_idx_t          ptr,
                                        input int unsigned        n);
    init_idx_t   idx;
    logic        found;
    int unsigned cand;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MaxInit; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= n) cand = cand - n;
      if (!found && (i < n) && req[cand]) begin
        idx   = init_idx_t'(cand);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/tcdm_rr_picker.sv
// Combinational winner selection: lowest-index starved requester first, else round-robin from ptr.
module tcdm_rr_picker
  import tcdm_arb_pkg::*;
#(
  parameter int unsigned NbInit = 4
) (
  input  logic [NbInit-1:0] req,
  input  logic [NbInit-1:0] starved,
  input  init_idx_t         ptr,
  output init_idx_t         winner,
  output logic              valid
);

  logic [MaxInit-1:0] req_pad;
  logic               starved_hit;
  init_idx_t          starved_idx;

  always_comb begin
    req_pad               = '0;
    req_pad[NbInit-1:0]   = req;
    starved_hit           = 1'b0;
    starved_idx           = '0;
    // Walk downwards so the lowest starved requester is the one left standing.
    for (int i = int'(NbInit) - 1; i >= 0; i--) begin
      if (starved[i] && req[i]) begin
        starved_hit = 1'b1;
        starved_idx = init_idx_t'(i);
      end
    end
    winner = starved_hit ? starved_idx : rr_pick(req_pad, ptr, NbInit);
  end

  assign valid = |req;

endmodule

// File: rtl/tcdm_bank_arbiter.sv
// Per-bank TCDM arbiter: merges NbInit initiators onto one SRAM bank port with round-robin,
// a starvation guard, a stall lock, and routing of the 1-cycle bank response.
module tcdm_bank_arbiter
  import tcdm_arb_pkg::*;
#(
  parameter  int unsigned NbInit    = 4,
  parameter  int unsigned DataWidth = 32,
  parameter  int unsigned AddrWidth = 32,
  parameter  int unsigned IdWidth   = 1,
  parameter  int unsigned MaxStall  = 15,
  localparam int unsigned BeWidth   = DataWidth / 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NbInit-1:0]             init_req_i,
  input  logic [NbInit-1:0]             init_wen_i,
  input  logic [NbInit*AddrWidth-1:0]   init_add_i,
  input  logic [NbInit*DataWidth-1:0]   init_data_i,
  input  logic [NbInit*BeWidth-1:0]     init_be_i,
  output logic [NbInit-1:0]             init_gnt_o,
  output logic [NbInit-1:0]             init_rvld_o,
  output logic [DataWidth-1:0]          init_rdata_o,
  output logic                          bank_req_o,
  output logic                          bank_wen_o,
  output logic [AddrWidth-1:0]          bank_add_o,
  output logic [DataWidth-1:0]          bank_data_o,
  output logic [BeWidth-1:0]            bank_be_o,
  output logic [IdWidth-1:0]            bank_id_o,
  input  logic                          bank_gnt_i,
  input  logic [DataWidth-1:0]          bank_rdata_i,
  input  logic [IdWidth-1:0]            bank_rid_i
);

  localparam int unsigned CntW = $clog2(MaxStall + 1);

  // Handshake: an initiator's request is accepted in the cycle init_req_i[k] and
  // init_gnt_o[k] are both high; its response (read or write) appears on init_rvld_o[k]
  // exactly one cycle later. Upstream the bank accepts when bank_req_o & bank_gnt_i.

  arb_state_t        state_q;
  logic [CntW-1:0]   stall_cnt_q [NbInit];
  logic [NbInit-1:0] starved;
  init_idx_t         pick_idx;
  init_idx_t         win;
  logic              any_req;
  logic              lock_hold;
  logic              granted;

  always_comb begin
    for (int i = 0; i < int'(NbInit); i++) begin
      starved[i] = (stall_cnt_q[i] == CntW'(MaxStall));
    end
  end

  tcdm_rr_picker #(
    .NbInit (NbInit)
  ) u_picker (
    .req     (init_req_i),
    .starved (starved),
    .ptr     (state_q.rr_ptr),
    .winner  (pick_idx),
    .valid   (any_req)
  );

  // A stalled request keeps the bank port until granted, unless its owner withdraws.
  always_comb begin
    lock_hold = 1'b0;
    for (int i = 0; i < int'(NbInit); i++) begin
      if (state_q.lock && (state_q.locked_idx == init_idx_t'(i)) && init_req_i[i]) begin
        lock_hold = 1'b1;
      end
    end
    win = lock_hold ? state_q.locked_idx : pick_idx;
  end

  // Outputs are held at zero while reset is asserted.
  always_comb begin
    bank_req_o  = rst_ni & any_req;
    bank_wen_o  = 1'b0;
    bank_add_o  = '0;
    bank_data_o = '0;
    bank_be_o   = '0;
    bank_id_o   = '0;
    init_gnt_o  = '0;
    for (int i = 0; i < int'(NbInit); i++) begin
      if (rst_ni && any_req && (win == init_idx_t'(i))) begin
        bank_wen_o    = init_wen_i[i];
        bank_add_o    = init_add_i[i*AddrWidth +: AddrWidth];
        bank_data_o   = init_data_i[i*DataWidth +: DataWidth];
        bank_be_o     = init_be_i[i*BeWidth +: BeWidth];
        bank_id_o     = IdWidth'(win);
        init_gnt_o[i] = bank_gnt_i & init_req_i[i];
      end
    end
  end

  assign granted = |init_gnt_o;

  always_comb begin
    init_rvld_o = '0;
    for (int i = 0; i < int'(NbInit); i++) begin
      init_rvld_o[i] = rst_ni & state_q.rvld & (state_q.ridx == init_idx_t'(i));
    end
  end

  assign init_rdata_o = bank_rdata_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= '0;
    end else begin
      if (bank_req_o && !bank_gnt_i) begin
        state_q.lock       <= 1'b1;
        state_q.locked_idx <= win;
      end else begin
        state_q.lock       <= 1'b0;
      end
      if (granted) begin
        state_q.rr_ptr <= (win == init_idx_t'(NbInit - 1)) ? '0 : win + init_idx_t'(1);
      end
      state_q.rvld <= granted;
      state_q.ridx <= win;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NbInit); i++) stall_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NbInit); i++) begin
        if (!init_req_i[i] || init_gnt_o[i]) begin
          stall_cnt_q[i] <= '0;
        end else if (!starved[i]) begin
          stall_cnt_q[i] <= stall_cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(init_gnt_o));
  assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(init_rvld_o));
  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   state_q.rvld |-> (bank_rid_i == IdWidth'(state_q.ridx)));

endmodule

// File: tb/tb_tcdm_bank_arbiter.sv
// Directed bench for tcdm_bank_arbiter (4 initiators, MaxStall=3) against a small SRAM bank model.
module tb_tcdm_bank_arbiter;

  logic         clk;
  logic         rst_ni;
  logic         preload;
  logic [3:0]   req;
  logic [3:0]   wen;
  logic [31:0]  add   [4];
  logic [31:0]  wdata [4];
  logic [3:0]   be    [4];
  logic         bank_gnt;

  logic [127:0] init_add;
  logic [127:0] init_data;
  logic [15:0]  init_be;
  logic [3:0]   init_gnt;
  logic [3:0]   init_rvld;
  logic [31:0]  init_rdata;
  logic         bank_req;
  logic         bank_wen;
  logic [31:0]  bank_add;
  logic [31:0]  bank_data;
  logic [3:0]   bank_be;
  logic [1:0]   bank_id;
  logic [31:0]  bank_rdata;
  logic [1:0]   bank_rid;
  logic [31:0]  mem [16];

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    init_add  = '0;
    init_data = '0;
    init_be   = '0;
    for (int i = 0; i < 4; i++) begin
      init_add[i*32 +: 32] = add[i];
      init_data[i*32 +: 32] = wdata[i];
      init_be[i*4 +: 4]    = be[i];
    end
  end

  tcdm_bank_arbiter #(
    .NbInit    (4),
    .DataWidth (32),
    .AddrWidth (32),
    .IdWidth   (2),
    .MaxStall  (3)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .init_req_i   (req),
    .init_wen_i   (wen),
    .init_add_i   (init_add),
    .init_data_i  (init_data),
    .init_be_i    (init_be),
    .init_gnt_o   (init_gnt),
    .init_rvld_o  (init_rvld),
    .init_rdata_o (init_rdata),
    .bank_req_o   (bank_req),
    .bank_wen_o   (bank_wen),
    .bank_add_o   (bank_add),
    .bank_data_o  (bank_data),
    .bank_be_o    (bank_be),
    .bank_id_o    (bank_id),
    .bank_gnt_i   (bank_gnt),
    .bank_rdata_i (bank_rdata),
    .bank_rid_i   (bank_rid)
  );

  // Bank model: registered read data and id, byte-enabled writes, word index from add[5:2].
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'hA000_0000 + 32'(i);
      bank_rdata <= 32'hDEAD_BEEF;
      bank_rid   <= 2'd0;
    end else if (bank_req && bank_gnt) begin
      bank_rdata <= mem[bank_add[5:2]];
      bank_rid   <= bank_id;
      if (!bank_wen) begin
        for (int b = 0; b < 4; b++) begin
          if (bank_be[b]) mem[bank_add[5:2]][b*8 +: 8] <= bank_data[b*8 +: 8];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_ni   = 1'b0;
    preload  = 1'b1;
    req      = 4'b0000;
    wen      = 4'b1111;
    bank_gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      add[i]   = 32'(i * 4);
      wdata[i] = 32'h0;
      be[i]    = 4'hF;
    end

    // Reset: outputs quiet even with requests present, rdata passes through.
    next_cycle();
    preload = 1'b0;
    req     = 4'b1111;
    #1;
    check("rst_gnt",      32'(init_gnt),  32'h0);
    check("rst_bank_req", 32'(bank_req),  32'h0);
    check("rst_rvld",     32'(init_rvld), 32'h0);
    check("rst_rdata",    init_rdata,     32'hDEAD_BEEF);

    // All four requesting: strict rotation, each response one cycle behind its grant.
    next_cycle();
    rst_ni = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) next_cycle();
      #1;
      check("rr_gnt",  32'(init_gnt), 32'(4'b0001 << (k % 4)));
      check("rr_id",   32'(bank_id),  32'(k % 4));
      check("rr_add",  bank_add,      32'((k % 4) * 4));
      if (k == 0) check("rr_rvld0", 32'(init_rvld), 32'h0);
      else begin
        check("rr_rvld",  32'(init_rvld), 32'(4'b0001 << ((k - 1) % 4)));
        check("rr_rdata", init_rdata,     32'hA000_0000 + 32'((k - 1) % 4));
      end
    end
    next_cycle();
    req = 4'b0000;
    #1;
    check("rr_last_rvld",  32'(init_rvld), 32'h8);
    check("rr_last_rdata", init_rdata,     32'hA000_0003);
    check("idle_bank_req", 32'(bank_req),  32'h0);

    // Single read from initiator 2 at 0x10.
    next_cycle();
    req = 4'b0100; add[2] = 32'h10; wen[2] = 1'b1;
    #1;
    check("rd2_gnt", 32'(init_gnt), 32'h4);
    check("rd2_add", bank_add,      32'h10);
    check("rd2_wen", 32'(bank_wen), 32'h1);
    next_cycle();
    req = 4'b0000;
    #1;
    check("rd2_rvld",  32'(init_rvld), 32'h4);
    check("rd2_rdata", init_rdata,     32'hA000_0004);

    // Bank stalls: initiator 1 keeps the port while initiator 3 waits.
    next_cycle();
    req = 4'b0010; add[1] = 32'h20; add[3] = 32'h30; bank_gnt = 1'b0;
    #1;
    check("lock_add_a", bank_add,      32'h20);
    check("lock_gnt_a", 32'(init_gnt), 32'h0);
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      req = 4'b1010;
      #1;
      check("lock_add_b", bank_add,      32'h20);
      check("lock_id_b",  32'(bank_id),  32'h1);
      check("lock_gnt_b", 32'(init_gnt), 32'h0);
    end
    next_cycle();
    bank_gnt = 1'b1;
    #1;
    check("lock_gnt_1", 32'(init_gnt), 32'h2);
    check("lock_add_1", bank_add,      32'h20);
    next_cycle();
    req = 4'b1000;
    #1;
    check("lock_gnt_3",   32'(init_gnt), 32'h8);
    check("lock_rvld_1",  32'(init_rvld), 32'h2);
    check("lock_rdata_1", init_rdata,     32'hA000_0008);
    next_cycle();
    req = 4'b0000;
    #1;
    check("lock_rvld_3",  32'(init_rvld), 32'h8);
    check("lock_rdata_3", init_rdata,     32'hA000_000C);

    // Starvation: pointer skewed past initiator 0, then it must win on its 4th waiting cycle.
    for (int i = 0; i < 4; i++) add[i] = 32'(i * 4);
    next_cycle();
    req = 4'b0001;
    #1;
    check("stv_gnt_c0", 32'(init_gnt), 32'h1);
    next_cycle();
    req = 4'b1111; bank_gnt = 1'b0;
    #1;
    check("stv_gnt_c1",  32'(init_gnt),  32'h0);
    check("stv_id_c1",   32'(bank_id),   32'h1);
    check("stv_rvld_c1", 32'(init_rvld), 32'h1);
    next_cycle();
    bank_gnt = 1'b1;
    #1;
    check("stv_gnt_c2", 32'(init_gnt), 32'h2);
    next_cycle();
    #1;
    check("stv_gnt_c3", 32'(init_gnt), 32'h4);
    next_cycle();
    #1;
    check("stv_gnt_c4", 32'(init_gnt), 32'h1);
    check("stv_id_c4",  32'(bank_id),  32'h0);
    next_cycle();
    #1;
    check("stv_gnt_c5",  32'(init_gnt),  32'h8);
    check("stv_rvld_c5", 32'(init_rvld), 32'h1);
    next_cycle();
    req = 4'b0000;
    #1;
    check("stv_rvld_c6", 32'(init_rvld), 32'h8);

    // Reset right after a grant: response dropped, pointer back to 0.
    next_cycle();
    req = 4'b0100; add[2] = 32'h10;
    #1;
    check("mrst_gnt", 32'(init_gnt), 32'h4);
    next_cycle();
    req = 4'b0000; rst_ni = 1'b0;
    #1;
    check("mrst_rvld_in", 32'(init_rvld), 32'h0);
    next_cycle();
    rst_ni = 1'b1;
    #1;
    check("mrst_rvld_out", 32'(init_rvld), 32'h0);
    next_cycle();
    req = 4'b1111;
    #1;
    check("mrst_ptr_gnt", 32'(init_gnt), 32'h1);
    next_cycle();
    req = 4'b0000;
    #1;
    check("mrst_rvld", 32'(init_rvld), 32'h1);

    // Write from 3, read back by 0, partial write from 1, read back by 2.
    next_cycle();
    req = 4'b1000; wen[3] = 1'b0; add[3] = 32'h24; wdata[3] = 32'h1234_5678; be[3] = 4'hF;
    #1;
    check("wr3_gnt",  32'(init_gnt), 32'h8);
    check("wr3_id",   32'(bank_id),  32'h3);
    check("wr3_wen",  32'(bank_wen), 32'h0);
    check("wr3_data", bank_data,     32'h1234_5678);
    next_cycle();
    req = 4'b0001; wen[0] = 1'b1; add[0] = 32'h24;
    #1;
    check("rd0_gnt",  32'(init_gnt),  32'h1);
    check("rd0_id",   32'(bank_id),   32'h0);
    check("wr3_rvld", 32'(init_rvld), 32'h8);
    next_cycle();
    req = 4'b0010; wen[1] = 1'b0; add[1] = 32'h24; wdata[1] = 32'hAAAA_BBBB; be[1] = 4'b0011;
    #1;
    check("rd0_rvld",  32'(init_rvld), 32'h1);
    check("rd0_rdata", init_rdata,     32'h1234_5678);
    check("wr1_gnt",   32'(init_gnt),  32'h2);
    check("wr1_be",    32'(bank_be),   32'h3);
    next_cycle();
    req = 4'b0100; wen[2] = 1'b1; add[2] = 32'h24;
    #1;
    check("rd2b_gnt", 32'(init_gnt),  32'h4);
    check("wr1_rvld", 32'(init_rvld), 32'h2);

    // Locked initiator withdraws: lock released and the other requester served at once.
    next_cycle();
    req = 4'b0010; wen[1] = 1'b1; add[1] = 32'h20; bank_gnt = 1'b0;
    #1;
    check("rd2b_rvld",  32'(init_rvld), 32'h4);
    check("rd2b_rdata", init_rdata,     32'h1234_BBBB);
    check("drop_gnt_a", 32'(init_gnt),  32'h0);
    check("drop_add_a", bank_add,       32'h20);
    next_cycle();
    req = 4'b0100; bank_gnt = 1'b1;
    #1;
    check("drop_gnt_b", 32'(init_gnt), 32'h4);
    check("drop_add_b", bank_add,      32'h24);
    next_cycle();
    req = 4'b0000;
    #1;
    check("drop_rvld", 32'(init_rvld), 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
